// File: rtl/ir_transmitter_pkg.sv
// ============================================================================
// Module      : ir_transmitter_pkg
// Description : Shared protocol constants, state encoding and helpers for the
//               pulse-width IR protocol (transmitter side; the receiver is
//               meant to import the same package).
//               Frame = 4-unit start mark, then 12 data bits LSB first, each
//               a 1-unit (bit 0) or 2-unit (bit 1) mark preceded by a 1-unit
//               space, then a trailing gap.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ir_transmitter_pkg;

   // Unit multipliers, in multiples of BASE_PULSE_WIDTH
   localparam int START_UNITS = 4;
   localparam int ZERO_UNITS  = 1;
   localparam int ONE_UNITS   = 2;
   localparam int SPACE_UNITS = 1;

   // Data bits per frame
   localparam int FRAME_BITS  = 12;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_SPACE = 3'd2,
      ST_BIT   = 3'd3,
      ST_GAP   = 3'd4
   } tx_state_t;

   // Longest single interval in units; sizes the duration counter.
   function automatic int max_units(input int gap_units);
      int m;
      m = START_UNITS;
      if (ONE_UNITS > m) m = ONE_UNITS;
      if (gap_units > m) m = gap_units;
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ir_transmitter_carrier_gen.sv
// ============================================================================
// Module      : ir_carrier_gen
// Description : Gated carrier generator for the IR LED. While enable is high
//               the output toggles every CARRIER_HALF_PERIOD cycles; the
//               phase restarts high on every rising edge of enable. Output is
//               0 whenever enable is low. CARRIER_HALF_PERIOD = 0 passes
//               enable straight through (registered), i.e. no modulation.
//               enable is expected to be the next-cycle mark indication so
//               the registered carrier lines up with the registered envelope.
// Ports       : clk     - clock
//               rst_n   - asynchronous active-low reset
//               enable  - mark indication (next-cycle value)
//               carrier - registered, gated carrier
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_carrier_gen #(
   parameter int CARRIER_HALF_PERIOD = 625
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic carrier
);

   generate
      if (CARRIER_HALF_PERIOD == 0) begin : g_unmodulated
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) carrier <= 1'b0;
            else        carrier <= enable;
         end
      end else begin : g_modulated
         localparam int CNT_W = (CARRIER_HALF_PERIOD > 1) ? $clog2(CARRIER_HALF_PERIOD) : 1;
         localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CARRIER_HALF_PERIOD - 1);

         logic [CNT_W-1:0] r_cnt;
         logic             r_enable_d;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt      <= '0;
               r_enable_d <= 1'b0;
               carrier    <= 1'b0;
            end else begin
               r_enable_d <= enable;
               if (!enable) begin
                  r_cnt   <= '0;
                  carrier <= 1'b0;
               end else if (!r_enable_d) begin
                  // New mark: restart with the phase high
                  r_cnt   <= '0;
                  carrier <= 1'b1;
               end else if (r_cnt == c_half_last) begin
                  r_cnt   <= '0;
                  carrier <= ~carrier;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/ir_transmitter.sv
// ============================================================================
// Module      : ir_transmitter
// Description : Pulse-width IR frame transmitter. Accepts one 12-bit word per
//               frame through a send/busy handshake and emits the frame as an
//               active-low envelope (receiver polarity) plus an active-high,
//               carrier-modulated LED drive.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               data   - word to send, sampled on the accept cycle only
//               send   - request; accepted on a clock edge while not busy
//               busy   - frame in progress, including the trailing gap
//               done   - one-cycle pulse on the cycle busy falls
//               ir     - envelope, 0 during a mark, idle 1
//               ir_led - LED drive, carrier during a mark, otherwise 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_transmitter
   import ir_transmitter_pkg::*;
#(
   parameter int BASE_PULSE_WIDTH    = 30000,
   parameter int CARRIER_HALF_PERIOD = 625,
   parameter int GAP_UNITS           = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FRAME_BITS-1:0] data,
   input  logic                  send,
   output logic                  busy,
   output logic                  done,
   output logic                  ir,
   output logic                  ir_led
);

   localparam int DUR_W = $clog2(max_units(GAP_UNITS) * BASE_PULSE_WIDTH);
   localparam int BIT_W = $clog2(FRAME_BITS + 1);

   // Terminal counts: each interval lasts units*BASE cycles (0 .. N*BASE-1)
   localparam logic [DUR_W-1:0] c_start_last = DUR_W'(START_UNITS * BASE_PULSE_WIDTH - 1);
   localparam logic [DUR_W-1:0] c_space_last = DUR_W'(SPACE_UNITS * BASE_PULSE_WIDTH - 1);
   localparam logic [DUR_W-1:0] c_zero_last  = DUR_W'(ZERO_UNITS  * BASE_PULSE_WIDTH - 1);
   localparam logic [DUR_W-1:0] c_one_last   = DUR_W'(ONE_UNITS   * BASE_PULSE_WIDTH - 1);
   localparam logic [DUR_W-1:0] c_gap_last   = DUR_W'(GAP_UNITS   * BASE_PULSE_WIDTH - 1);
   localparam logic [BIT_W-1:0] c_last_bit   = BIT_W'(FRAME_BITS - 1);

   tx_state_t             r_state;
   logic [DUR_W-1:0]      r_dur;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [FRAME_BITS-1:0] r_shift;

   tx_state_t             w_state_next;
   logic [DUR_W-1:0]      w_dur_next;
   logic [BIT_W-1:0]      w_bit_next;
   logic [FRAME_BITS-1:0] w_shift_next;
   logic                  w_dur_last;
   logic                  w_done_next;
   logic                  w_busy_next;
   logic                  w_mark_next;

   // End of the current interval
   always_comb begin
      w_dur_last = 1'b0;
      case (r_state)
         ST_START: w_dur_last = (r_dur == c_start_last);
         ST_SPACE: w_dur_last = (r_dur == c_space_last);
         ST_BIT:   w_dur_last = (r_dur == (r_shift[0] ? c_one_last : c_zero_last));
         ST_GAP:   w_dur_last = (r_dur == c_gap_last);
         default:  w_dur_last = 1'b0;
      endcase
   end

   // Next state, datapath next values and next registered outputs
   always_comb begin
      w_state_next = r_state;
      w_dur_next   = r_dur + 1'b1;
      w_bit_next   = r_bit_cnt;
      w_shift_next = r_shift;
      w_done_next  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_dur_next = '0;
            // busy is registered from the state, so IDLE here means busy=0
            if (send) begin
               w_state_next = ST_START;
               w_shift_next = data;
               w_bit_next   = '0;
            end
         end
         ST_START: begin
            if (w_dur_last) begin
               w_state_next = ST_SPACE;
               w_dur_next   = '0;
            end
         end
         ST_SPACE: begin
            if (w_dur_last) begin
               w_state_next = ST_BIT;
               w_dur_next   = '0;
            end
         end
         ST_BIT: begin
            if (w_dur_last) begin
               w_dur_next   = '0;
               w_shift_next = {1'b0, r_shift[FRAME_BITS-1:1]};
               w_bit_next   = r_bit_cnt + 1'b1;
               // No space after the last bit: the gap follows directly
               w_state_next = (r_bit_cnt == c_last_bit) ? ST_GAP : ST_SPACE;
            end
         end
         ST_GAP: begin
            if (w_dur_last) begin
               w_state_next = ST_IDLE;
               w_dur_next   = '0;
               w_done_next  = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_dur_next   = '0;
         end
      endcase

      w_mark_next = (w_state_next == ST_START) || (w_state_next == ST_BIT);
      w_busy_next = (w_state_next != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_dur     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ir        <= 1'b1;
      end else begin
         r_state   <= w_state_next;
         r_dur     <= w_dur_next;
         r_bit_cnt <= w_bit_next;
         r_shift   <= w_shift_next;
         busy      <= w_busy_next;
         done      <= w_done_next;
         ir        <= ~w_mark_next;
      end
   end

   // Fed with the next-cycle mark so its registered output aligns with ir
   ir_carrier_gen #(
      .CARRIER_HALF_PERIOD (CARRIER_HALF_PERIOD)
   ) u_carrier (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (w_mark_next),
      .carrier (ir_led)
   );

endmodule

`default_nettype wire

// File: tb/tb_ir_transmitter.sv
// ============================================================================
// Module      : tb_ir_transmitter
// Description : Scoreboard bench for ir_transmitter. Stimulus pushes the word
//               and hand-computed frame length of every frame expected to
//               complete; a monitor measures marks/spaces on ir, decodes the
//               word, checks the LED carrier, and compares on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ir_transmitter;

   localparam int BASE = 10;
   localparam int HALF = 2;
   localparam int GAP  = 4;

   logic        clk;
   logic        rst_n;
   logic        send;
   logic [11:0] data;
   logic        busy;
   logic        done;
   logic        ir;
   logic        ir_led;

   ir_transmitter #(
      .BASE_PULSE_WIDTH    (BASE),
      .CARRIER_HALF_PERIOD (HALF),
      .GAP_UNITS           (GAP)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .data   (data),
      .send   (send),
      .busy   (busy),
      .done   (done),
      .ir     (ir),
      .ir_led (ir_led)
   );

   typedef struct {
      logic [11:0] word;
      int          len;
   } exp_t;

   exp_t exp_q[$];
   int   checks      = 0;
   int   errors      = 0;
   int   frames_done = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   initial begin : monitor
      int          cyc;
      int          low_run;
      int          high_run;
      int          t_acc;
      int          led_bad;
      int          start_rises;
      int          bad_marks;
      int          bad_spaces;
      int          p;
      logic        prev_busy;
      logic        prev_ir;
      logic        prev_led;
      logic        prev_done;
      logic        exp_led;
      bit          in_frame;
      logic [11:0] word;
      exp_t        e;
      int          marks[$];
      int          spaces[$];

      cyc = 0; low_run = 0; high_run = 0; t_acc = 0; led_bad = 0; start_rises = 0;
      prev_busy = 1'b0; prev_ir = 1'b1; prev_led = 1'b0; prev_done = 1'b0; in_frame = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            in_frame = 1'b0; prev_busy = 1'b0; prev_ir = 1'b1; prev_led = 1'b0;
            prev_done = 1'b0; low_run = 0; high_run = 0;
            marks.delete(); spaces.delete();
            continue;
         end

         if (busy && !prev_busy) begin
            check("idle high before frame", (high_run >= 4*BASE) ? 1 : 0, 1);
            in_frame = 1'b1; t_acc = cyc; led_bad = 0; start_rises = 0;
            marks.delete(); spaces.delete();
         end

         if (done) begin
            check("done single cycle", prev_done, 0);
            check("done with frame queued", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               frames_done++;
               check("frame length", cyc - t_acc, e.len);
               check("mark count", marks.size(), 13);
               check("start mark length", (marks.size() > 0) ? marks[0] : 0, 4*BASE);
               word = '0; bad_marks = 0; bad_spaces = 0;
               for (int i = 1; i < marks.size() && i <= 12; i++) begin
                  if (marks[i] == 2*BASE)   word[i-1] = 1'b1;
                  else if (marks[i] != BASE) bad_marks++;
               end
               for (int i = 0; i < spaces.size(); i++)
                  if (spaces[i] != BASE) bad_spaces++;
               check("decoded word", word, e.word);
               check("bad mark lengths", bad_marks, 0);
               check("space count", spaces.size(), 12);
               check("bad space lengths", bad_spaces, 0);
               check("trailing gap", high_run, GAP*BASE);
               check("led carrier errors", led_bad, 0);
               check("start mark led rises", start_rises, 10);
               check("busy low at done", busy, 0);
            end
            in_frame = 1'b0;
         end

         // Position within the current mark (0 at the first low sample)
         p = prev_ir ? 0 : low_run;
         if (in_frame) begin
            if (ir) begin
               if (ir_led !== 1'b0) led_bad++;
            end else begin
               exp_led = (((p / HALF) % 2) == 0);
               if (ir_led !== exp_led) led_bad++;
               if (marks.size() == 0 && ir_led && !prev_led) start_rises++;
            end
         end

         if (!ir) begin
            if (prev_ir) begin
               if (in_frame && marks.size() > 0) spaces.push_back(high_run);
               low_run = 0;
            end
            low_run++;
         end else begin
            if (!prev_ir) begin
               if (in_frame) marks.push_back(low_run);
               high_run = 0;
            end
            high_run++;
         end

         prev_busy = busy; prev_ir = ir; prev_led = ir_led; prev_done = done;
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic send_word(input logic [11:0] d, input int len, input bit push);
      int n;
      n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("idle before send", busy, 0);
      data = d;
      send = 1'b1;
      if (push) exp_q.push_back('{d, len});
      @(negedge clk);
      send = 1'b0;
      check("busy after accept", busy, 1);
      check("ir low after accept", ir, 0);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 2000);
      check(name, done, 1);
   endtask

   initial begin : stimulus
      int bad;
      int n;
      rst_n = 1'b0;
      send  = 1'b0;
      data  = '0;
      repeat (3) @(negedge clk);
      check("reset ir", ir, 1);
      check("reset ir_led", ir_led, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      rst_n = 1'b1;

      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (ir !== 1'b1 || ir_led !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      check("idle outputs stable", bad, 0);

      // 32B and 38B frames
      send_word(12'h000, 320, 1'b1);
      send_word(12'hA5C, 380, 1'b1);

      // Request and data change mid-frame are ignored; send held at done
      send_word(12'h3C1, 370, 1'b1);
      repeat (49) @(negedge clk);
      data = 12'hFFF;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      repeat (9) @(negedge clk);
      data = 12'h456;
      send = 1'b1;
      exp_q.push_back('{12'h456, 370});
      wait_done("done of 0x3C1 frame");
      @(negedge clk);
      check("back-to-back accept", busy, 1);
      send = 1'b0;
      wait_done("done of 0x456 frame");

      // Asynchronous reset in the first data mark (bit 0 = 1, 20 long)
      send_word(12'h0FF, 0, 1'b0);
      repeat (55) @(negedge clk);
      check("mark before reset", ir, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async reset ir", ir, 1);
      check("async reset ir_led", ir_led, 0);
      check("async reset busy", busy, 0);
      check("async reset done", done, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);

      // Longest frame after reset recovery
      send_word(12'hFFF, 440, 1'b1);

      n = 0;
      while ((busy || exp_q.size() > 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("scoreboard drained", exp_q.size(), 0);
      check("frames completed", frames_done, 5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
